data_sram_responder: RTL and testbench

- Data-memory responder answering the data SRAM requests issued by EX; its read data is consumed by the MEM stage.
- Holds a word-addressed RAM array with byte-lane writes and a registered read port.
- Inserts WAIT_CYCLES programmable wait states per access and raises a stall request to the pipeline stall controller while an access is outstanding.

---
 rtl/data_sram_responder.sv | 177 +++++++++++++++++
 tb/tb_data_sram_responder.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_responder.sv
// data_sram_responder
//
// Data-memory responder for the EX-stage data SRAM requests. It holds a
// word-addressed 32-bit RAM with byte-lane writes and a registered read
// port whose output is consumed by MEM. Each access can be stretched by
// WAIT_CYCLES wait states. While an access is outstanding a stall request
// is raised towards the pipeline stall controller.
//
// Parameters:
//   ADDR_W       word-address width, array depth 2**ADDR_W words
//   WAIT_CYCLES  extra cycles per access, legal range 0..15 (0 = single cycle)
//
// Ports:
//   clk              clock, rising edge
//   rst              asynchronous active-low reset
//   data_sram_en     access request
//   data_sram_wen    byte-lane write enables (4'b0000 = read)
//   data_sram_addr   byte address, bits [1:0] ignored
//   data_sram_wdata  write data, lane i = wdata[8i+7:8i]
//   data_sram_rdata  registered read data
//   stallreq_mem     stall request to the stall controller
//   fsm_state        current FSM state (0 = IDLE, 1 = WAIT) for checkers
//   data_sram_err    sticky out-of-range flag (only with DSRAM_ERR_EN)
//
// Optional feature macro: DSRAM_ERR_EN adds data_sram_err.
//
// Handshake: a request is taken when data_sram_en=1 in IDLE. Completion
// occurs at the edge where the access is not stalled. stallreq_mem is high
// in every cycle of an access except the last. Bus inputs are ignored while
// in WAIT.

module data_sram_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        stallreq_mem,
    output logic        fsm_state
`ifdef DSRAM_ERR_EN
    ,
    output logic        data_sram_err
`endif
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;

    // Request latched at acceptance time when wait states are used.
    logic [3:0]  req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    // The access being serviced this cycle (bus in IDLE, latch in WAIT).
    logic [3:0]  acc_wen;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;

    logic        latch_req;
    logic        complete;
    logic        in_range;
    logic        rd_fire;
    logic        wr_fire;
    logic [ADDR_W-1:0] idx;

    logic [31:0] mem [2**ADDR_W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        latch_req    = 1'b0;
        complete     = 1'b0;
        stallreq_mem = 1'b0;
        acc_wen      = data_sram_wen;
        acc_addr     = data_sram_addr;
        acc_wdata    = data_sram_wdata;
        case (state)
            S_IDLE: begin
                if (data_sram_en) begin
                    if (WAIT_CYCLES == 0) begin
                        complete = 1'b1;
                    end else begin
                        latch_req    = 1'b1;
                        cnt_next     = 4'(WAIT_CYCLES);
                        state_next   = S_WAIT;
                        stallreq_mem = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                acc_wen   = req_wen;
                acc_addr  = req_addr;
                acc_wdata = req_wdata;
                cnt_next  = cnt - 4'd1;
                if (cnt > 4'd1) begin
                    stallreq_mem = 1'b1;
                end else begin
                    // Last wait cycle: stall drops and the access retires.
                    complete   = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign fsm_state = state;

    // Anything above the array's byte span is out of range.
    assign in_range = (acc_addr >> (ADDR_W + 2)) == 32'd0;
    assign idx      = acc_addr[ADDR_W+1:2];
    assign rd_fire  = complete && (acc_wen == 4'b0000);
    // Gating with rst keeps a write from landing while reset is held.
    assign wr_fire  = complete && (acc_wen != 4'b0000) && in_range && rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_wen         <= 4'd0;
            req_addr        <= 32'd0;
            req_wdata       <= 32'd0;
            data_sram_rdata <= 32'd0;
        end else begin
            if (latch_req) begin
                req_wen   <= data_sram_wen;
                req_addr  <= data_sram_addr;
                req_wdata <= data_sram_wdata;
            end
            if (rd_fire) begin
                data_sram_rdata <= in_range ? mem[idx] : 32'd0;
            end
        end
    end

    // Array contents survive reset, so this block has no reset branch.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_wen[i]) begin
                    mem[idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

`ifdef DSRAM_ERR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_sram_err <= 1'b0;
        end else if (complete && !in_range) begin
            data_sram_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_data_sram_responder.sv
// Testbench for data_sram_responder. Three instances share clock and reset:
// instance 0 with WAIT_CYCLES=0, instance 1 with 3, instance 2 with 4.
// A reference memory (associative array of words per instance) predicts
// read data; stall timing is predicted from the wait count alone.

module tb_data_sram_responder;

    logic clk = 1'b0;
    logic rst;

    logic [2:0]       en;
    logic [2:0][3:0]  wen;
    logic [2:0][31:0] addr;
    logic [2:0][31:0] wdata;
    logic [2:0][31:0] rdata;
    logic [2:0]       stall;
    logic [2:0]       fsm;
`ifdef DSRAM_ERR_EN
    logic [2:0]       err;
    logic [2:0]       exp_err;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem [int];
    logic [31:0] exp_rdata [3];
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    data_sram_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) u0 (
        .clk(clk), .rst(rst), .data_sram_en(en[0]), .data_sram_wen(wen[0]),
        .data_sram_addr(addr[0]), .data_sram_wdata(wdata[0]),
        .data_sram_rdata(rdata[0]), .stallreq_mem(stall[0]), .fsm_state(fsm[0])
`ifdef DSRAM_ERR_EN
        , .data_sram_err(err[0])
`endif
    );

    data_sram_responder #(.ADDR_W(10), .WAIT_CYCLES(3)) u1 (
        .clk(clk), .rst(rst), .data_sram_en(en[1]), .data_sram_wen(wen[1]),
        .data_sram_addr(addr[1]), .data_sram_wdata(wdata[1]),
        .data_sram_rdata(rdata[1]), .stallreq_mem(stall[1]), .fsm_state(fsm[1])
`ifdef DSRAM_ERR_EN
        , .data_sram_err(err[1])
`endif
    );

    data_sram_responder #(.ADDR_W(10), .WAIT_CYCLES(4)) u2 (
        .clk(clk), .rst(rst), .data_sram_en(en[2]), .data_sram_wen(wen[2]),
        .data_sram_addr(addr[2]), .data_sram_wdata(wdata[2]),
        .data_sram_rdata(rdata[2]), .stallreq_mem(stall[2]), .fsm_state(fsm[2])
`ifdef DSRAM_ERR_EN
        , .data_sram_err(err[2])
`endif
    );

    function automatic int wc_of(input int i);
        case (i)
            0:       return 0;
            1:       return 3;
            default: return 4;
        endcase
    endfunction

    // Reference behaviour: returns the word a read would deliver and applies
    // writes to the reference memory. Out-of-range: reads give 0, writes drop.
    function automatic logic [31:0] model_access(input int i, input logic [3:0] w,
                                                 input logic [31:0] a, input logic [31:0] d);
        int key;
        logic [31:0] mask;
        if (a >= 32'h0000_1000) return 32'd0;
        key = i * 1024 + int'(a / 4);
        if (w == 4'b0000) return ref_mem.exists(key) ? ref_mem[key] : 32'd0;
        mask = {{8{w[3]}}, {8{w[2]}}, {8{w[1]}}, {8{w[0]}}};
        ref_mem[key] = (ref_mem.exists(key) ? (ref_mem[key] & ~mask) : 32'd0) | (d & mask);
        return 32'd0;
    endfunction

    // Drives one access on instance i, scrambles the bus during the wait
    // states, and checks stall per cycle, rdata hold, and final rdata.
    task automatic do_access(input int i, input logic [3:0] w, input logic [31:0] a,
                             input logic [31:0] d, input string tag);
        int n;
        logic [31:0] old_rd;
        logic [31:0] rd;
        n = wc_of(i);
        old_rd = exp_rdata[i];
        @(negedge clk);
        en[i] = 1'b1; wen[i] = w; addr[i] = a; wdata[i] = d;
        #1;
        checks++;
        if (stall[i] !== (n > 0)) begin
            errors++;
            $display("FAIL %s stall_req_cycle: got %b expected %b", tag, stall[i], (n > 0));
        end
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            en[i] = 1'($urandom_range(0, 1));
            wen[i] = 4'($urandom);
            addr[i] = $urandom;
            wdata[i] = $urandom;
            #1;
            checks++;
            if (stall[i] !== (k < n) || rdata[i] !== old_rd) begin
                errors++;
                $display("FAIL %s wait_cycle%0d: stall %b rdata %h expected stall %b rdata %h",
                         tag, k, stall[i], rdata[i], (k < n), old_rd);
            end
        end
        @(negedge clk);
        en[i] = 1'b0; wen[i] = 4'd0; addr[i] = 32'd0; wdata[i] = 32'd0;
        rd = model_access(i, w, a, d);
        if (w == 4'b0000) exp_rdata[i] = rd;
`ifdef DSRAM_ERR_EN
        if (a >= 32'h0000_1000) exp_err[i] = 1'b1;
`endif
        #1;
        checks++;
        if (rdata[i] !== exp_rdata[i] || stall[i] !== 1'b0) begin
            errors++;
            $display("FAIL %s result: rdata %h stall %b expected rdata %h stall 0",
                     tag, rdata[i], stall[i], exp_rdata[i]);
        end
`ifdef DSRAM_ERR_EN
        checks++;
        if (err[i] !== exp_err[i]) begin
            errors++;
            $display("FAIL %s err_flag: got %b expected %b", tag, err[i], exp_err[i]);
        end
`endif
    endtask

    task automatic test_reset();
        rst = 1'b0;
        en = '0; wen = '0; addr = '0; wdata = '0;
        for (int i = 0; i < 3; i++) exp_rdata[i] = 32'd0;
`ifdef DSRAM_ERR_EN
        exp_err = '0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rdata[i] !== 32'd0 || stall[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state inst%0d: rdata %h stall %b expected 0 0", i, rdata[i], stall[i]);
            end
        end
        rst = 1'b1;
    endtask

    task automatic test_preload();
        for (int i = 0; i < 3; i++)
            for (int wd = 0; wd < 16; wd++)
                do_access(i, 4'hF, 32'(wd * 4), $urandom, "preload");
    endtask

    task automatic test_write_read();
        do_access(0, 4'hF, 32'h10, 32'hDEADBEEF, "w0_write");
        do_access(0, 4'h0, 32'h10, 32'h0, "w0_read");
        checks++;
        if (rdata[0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL w0_deadbeef: got %h expected deadbeef", rdata[0]);
        end
    endtask

    task automatic test_byte_lanes();
        for (int i = 0; i < 2; i++) begin
            do_access(i, 4'hF, 32'h20, 32'h11223344, "lanes_preload");
            do_access(i, 4'b0101, 32'h20, 32'hAABBCCDD, "lanes_write");
            do_access(i, 4'h0, 32'h20, 32'h0, "lanes_read");
            checks++;
            if (rdata[i] !== 32'h11BB33DD) begin
                errors++;
                $display("FAIL byte_lanes inst%0d: got %h expected 11bb33dd", i, rdata[i]);
            end
        end
    endtask

    // Instance 1 (three wait states); do_access checks the per-cycle stall
    // pattern and scrambles addr during WAIT.
    task automatic test_wait_timing();
        do_access(1, 4'hF, 32'h44, 32'h5A5A1234, "wait3_write");
        do_access(1, 4'h0, 32'h44, 32'h0, "wait3_read");
        do_access(1, 4'h0, 32'h10, 32'h0, "wait3_read2");
    endtask

    task automatic test_out_of_range();
        do_access(0, 4'hF, 32'h0, 32'hCAFE0001, "oor_preload");
        do_access(0, 4'h0, 32'h0, 32'h0, "oor_read_base");
        do_access(0, 4'h0, 32'h0000_1000, 32'h0, "oor_read");
        do_access(0, 4'hF, 32'h0000_1000, 32'h12345678, "oor_write");
        do_access(0, 4'h0, 32'h0, 32'h0, "oor_check_word0");
        checks++;
        if (rdata[0] !== 32'hCAFE0001) begin
            errors++;
            $display("FAIL oor_word0_intact: got %h expected cafe0001", rdata[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            if (k < 3) begin
                en[0] = 1'b1; wen[0] = 4'h0; addr[0] = 32'(k * 4);
                exp_q.push_back(model_access(0, 4'h0, 32'(k * 4), 32'h0));
            end else begin
                en[0] = 1'b0; addr[0] = 32'h0;
            end
            #1;
            checks++;
            if (stall[0] !== 1'b0) begin
                errors++;
                $display("FAIL b2b_stall cycle%0d: got %b expected 0", k, stall[0]);
            end
            if (k > 0) begin
                exp = exp_q.pop_front();
                exp_rdata[0] = exp;
                checks++;
                if (rdata[0] !== exp) begin
                    errors++;
                    $display("FAIL b2b_rdata read%0d: got %h expected %h", k - 1, rdata[0], exp);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_access();
        do_access(2, 4'hF, 32'h30, 32'h0BADF00D, "rst_preload");
        do_access(2, 4'h0, 32'h30, 32'h0, "rst_read_before");
        @(negedge clk);
        en[2] = 1'b1; wen[2] = 4'hF; addr[2] = 32'h30; wdata[2] = 32'h77777777;
        @(negedge clk);
        en[2] = 1'b0; wen[2] = 4'h0; addr[2] = 32'h0; wdata[2] = 32'h0;
        @(negedge clk);
        #1;
        checks++;
        if (stall[2] !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_in_wait: stall %b expected 1", stall[2]);
        end
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) exp_rdata[i] = 32'd0;
`ifdef DSRAM_ERR_EN
        exp_err = '0;
`endif
        checks++;
        if (stall[2] !== 1'b0 || rdata[2] !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid_immediate: stall %b rdata %h expected 0 00000000", stall[2], rdata[2]);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        do_access(2, 4'h0, 32'h30, 32'h0, "rst_read_after");
        checks++;
        if (rdata[2] !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL rst_write_abandoned: got %h expected 0badf00d", rdata[2]);
        end
    endtask

    task automatic test_random();
        int i;
        logic [3:0] w;
        logic [31:0] a;
        for (int n = 0; n < 60; n++) begin
            i = $urandom_range(0, 2);
            w = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            if ($urandom_range(0, 7) == 0)
                a = (32'h0000_1000 << $urandom_range(0, 19)) | 32'($urandom_range(0, 4095));
            else
                a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            do_access(i, w, a, $urandom, "random");
        end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_write_read();
        test_byte_lanes();
        test_wait_timing();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid_access();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
